piso_stream: RTL and testbench
==============================

Name: piso_stream

Overview:
- Parametrised parallel-in serial-out shifter. Successor to the basic 4-bit PISO.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it as WIDTH/LANES beats of LANES bits each, under downstream backpressure.
- Shift order (MSB-first or LSB-first) is selected by parameter.
- Flags the final beat of each word and supports back-to-back words with no idle cycle. Sits between a parallel datapath and a serial link/encoder.

Parameters:
- WIDTH, 8, parallel word width in bits; must be a multiple of LANES.
- LANES, 1, bits emitted per beat; 1 gives a classic single-bit serial output.
- MSB_FIRST, 1, 1 = most-significant lane shifted out first; 0 = least-significant first.

Ports:
- Clk  input  1  clock; all logic on rising edge.
- Rst  input  1  synchronous reset, active-high.
- In_Valid  input  1  Parallel_In holds a word to load.
- In_Ready  output  1  block can accept a word this cycle.
- Parallel_In  input  WIDTH  parallel word; sampled when In_Valid & In_Ready.
- Serial_Out  output  LANES  current beat data.
- Out_Valid  output  1  Serial_Out holds a valid beat.
- Out_Ready  input  1  downstream accepts the beat this cycle.
- Out_Last  output  1  current beat is the final beat of the word.
- Empty_Flag  output  1  no word held (IDLE).

Behaviour:
- BEATS = WIDTH/LANES. Beat counter width = $clog2(BEATS+1).
- Reset (Rst=1 at a rising edge): state=IDLE, shift register=0, counter=0, Out_Valid=0, Out_Last=0, Serial_Out=0, Empty_Flag=1, In_Ready=1.
- Reset overrides everything, including mid-word. A partially shifted word is discarded and no further beats of it appear.
- States:
  - IDLE: Empty_Flag=1, Out_Valid=0, In_Ready=1. On In_Valid, load Parallel_In, set counter=BEATS, go to SHIFT.
  - SHIFT: Empty_Flag=0, Out_Valid=1.
- Serial_Out in SHIFT:
  - MSB_FIRST=1: register bits [WIDTH-1 -: LANES].
  - MSB_FIRST=0: register bits [LANES-1:0].
- Beat transfer = Out_Valid & Out_Ready. On a transfer:
  - register shifts by LANES toward the output end; vacated bits fill with 0.
  - counter decrements by 1.
- Out_Last = SHIFT & (counter==1).
- Out_Ready low: register, counter and Serial_Out hold unchanged. Out_Valid stays high (it is never withdrawn).
- In_Ready = Empty_Flag | (Out_Last & Out_Ready). Combinational from Out_Ready; this is the only combinational in-to-out path.
- Last beat accepted together with In_Valid: new word loads, counter=BEATS, state stays SHIFT. The next cycle shows beat 0 of the new word (zero bubble).
- Last beat accepted without In_Valid: go to IDLE next cycle.
- In_Valid while In_Ready=0: ignored. The upstream must hold the word stable.
- Latency: word accepted at edge N → first beat valid after edge N (cycle N+1). A word takes BEATS cycles with Out_Ready held high.
- Parallel_In is don't-care when not accepted.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - Each word is followed by one extra parity beat: Serial_Out[0] = ^word (even parity over the loaded word), upper lanes 0.
  - Beat counter starts at BEATS+1.
  - Out_Last asserts on the parity beat only.
  - Parity is computed at load time and stored in a 1-bit register; it obeys the same backpressure, back-to-back and reset rules.
- Undefined: no parity register, no extra beat; behaviour exactly as above.

Test Plan:
- WIDTH=8, LANES=1, MSB_FIRST=1, Out_Ready=1, load 8'hC5 → Serial_Out 1,1,0,0,0,1,0,1 on consecutive cycles; Out_Last only on 8th beat; Empty_Flag=1 the cycle after.
- WIDTH=8, LANES=2, MSB_FIRST=0, load 8'hC5 → beats 2'b01, 2'b01, 2'b00, 2'b11; Out_Last on 4th.
- Backpressure (LANES=1, MSB_FIRST=1), 8'hA3: drop Out_Ready for 3 cycles after beat 2 → Serial_Out stays 0 and Out_Valid stays 1 during stall; full sequence 1,0,1,0,0,0,1,1 delivered exactly once.
- Back-to-back: In_Valid held with 8'hF0 then 8'h0F, Out_Ready=1 → 16 contiguous beats 11110000 00001111; Out_Valid never drops; In_Ready pulses with each Out_Last.
- Reset mid-word: assert Rst after 3 beats of 8'hFF → next cycle Out_Valid=0, Empty_Flag=1, Serial_Out=0; next load of 8'h01 emits 0,0,0,0,0,0,0,1.
- PISO_PARITY_EN defined: load 8'h07 (LANES=1) → 0,0,0,0,0,1,1,1 then parity beat 1 with Out_Last; load 8'h03 → parity beat 0.

Source files
------------

// File: rtl/piso_stream.sv
// Parallel-in serial-out shifter with valid/ready on both sides and a last-beat flag.
// Optional macro PISO_PARITY_EN appends an even-parity beat after each word.
module piso_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LANES     = 1,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] Parallel_In,
  output logic [LANES-1:0] Serial_Out,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Out_Last,
  output logic             Empty_Flag
);

  localparam int unsigned Beats = WIDTH / LANES;
`ifdef PISO_PARITY_EN
  localparam int unsigned NumBeats = Beats + 1;
`else
  localparam int unsigned NumBeats = Beats;
`endif
  localparam int unsigned CntW = $clog2(NumBeats + 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic in_ready, load, xfer, last;

  always_comb begin
    Empty_Flag = (state_q == StIdle);
    Out_Valid  = (state_q == StShift);
    last       = (state_q == StShift) && (cnt_q == CntW'(1));
    Out_Last   = last;
    in_ready   = Empty_Flag | (last & Out_Ready);
    In_Ready   = in_ready;
    load       = In_Valid & in_ready;
    xfer       = Out_Valid & Out_Ready;

    Serial_Out = '0;
    if (state_q == StShift) begin
      if (MSB_FIRST) Serial_Out = shift_q[WIDTH-1 -: LANES];
      else           Serial_Out = shift_q[LANES-1:0];
`ifdef PISO_PARITY_EN
      // Data bits are all shifted out by now; the final beat carries parity only.
      if (cnt_q == CntW'(1)) begin
        Serial_Out    = '0;
        Serial_Out[0] = parity_q;
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    // Load takes priority: it only happens alongside the final transfer or from idle.
    if (load) begin
      state_d = StShift;
      shift_d = Parallel_In;
      cnt_d   = CntW'(NumBeats);
`ifdef PISO_PARITY_EN
      parity_d = ^Parallel_In;
`endif
    end else if (xfer) begin
      if (MSB_FIRST) shift_d = shift_q << LANES;
      else           shift_d = shift_q >> LANES;
      cnt_d = cnt_q - CntW'(1);
      if (last) state_d = StIdle;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_stream.sv
// Directed self-checking bench for piso_stream: an MSB-first 1-lane instance and an
// LSB-first 2-lane instance, covering reset, ordering, backpressure, back-to-back and parity.
module tb_piso_stream;

`ifdef PISO_PARITY_EN
  localparam int Extra = 1;
`else
  localparam int Extra = 0;
`endif
  localparam int Bpw = 8 + Extra;

  logic       clk;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_last, empty;
  logic [7:0] par_in;
  logic [0:0] ser;

  logic       in_valid2, in_ready2, out_valid2, out_ready2, out_last2, empty2;
  logic [7:0] par_in2;
  logic [1:0] ser2;

  int tests = 0;
  int fails = 0;

  piso_stream #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b1)) dut (
    .Clk(clk), .Rst(rst), .In_Valid(in_valid), .In_Ready(in_ready), .Parallel_In(par_in),
    .Serial_Out(ser), .Out_Valid(out_valid), .Out_Ready(out_ready), .Out_Last(out_last),
    .Empty_Flag(empty)
  );

  piso_stream #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b0)) dut2 (
    .Clk(clk), .Rst(rst), .In_Valid(in_valid2), .In_Ready(in_ready2), .Parallel_In(par_in2),
    .Serial_Out(ser2), .Out_Valid(out_valid2), .Out_Ready(out_ready2), .Out_Last(out_last2),
    .Empty_Flag(empty2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if (out_valid !== 1'b0 || empty !== 1'b1 || in_ready !== 1'b1 || ser !== 1'b0 ||
        out_last !== 1'b0) begin
      fails++;
      $display("FAIL reset: valid=%b empty=%b in_ready=%b ser=%b last=%b, want 0 1 1 0 0",
               out_valid, empty, in_ready, ser, out_last);
    end
    tests++;
    if (out_valid2 !== 1'b0 || empty2 !== 1'b1 || in_ready2 !== 1'b1 || ser2 !== 2'b00) begin
      fails++;
      $display("FAIL reset2: valid=%b empty=%b in_ready=%b ser=%b, want 0 1 1 00",
               out_valid2, empty2, in_ready2, ser2);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_msb_first;
    logic [7:0] w;
    w = 8'hC5;
    in_valid = 1'b1; par_in = w; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < Bpw; i++) begin
      logic exp_bit;
      exp_bit = (i < 8) ? w[7-i] : ^w;
      tests++;
      if (out_valid !== 1'b1 || ser !== exp_bit || out_last !== (i == Bpw - 1)) begin
        fails++;
        $display("FAIL msb_first beat %0d: valid=%b ser=%b last=%b, want 1 %b %b",
                 i, out_valid, ser, out_last, exp_bit, (i == Bpw - 1));
      end
      tick();
    end
    tests++;
    if (empty !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL msb_first idle: empty=%b valid=%b, want 1 0", empty, out_valid);
    end
  endtask

  task automatic test_lanes2_lsb;
    logic [1:0] exp_beats [4];
    exp_beats[0] = 2'b01; exp_beats[1] = 2'b01; exp_beats[2] = 2'b00; exp_beats[3] = 2'b11;
    in_valid2 = 1'b1; par_in2 = 8'hC5; out_ready2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    for (int i = 0; i < 4 + Extra; i++) begin
      logic [1:0] e;
      e = (i < 4) ? exp_beats[i] : 2'b00;  // parity of C5 is 0
      tests++;
      if (out_valid2 !== 1'b1 || ser2 !== e || out_last2 !== (i == 3 + Extra)) begin
        fails++;
        $display("FAIL lanes2 beat %0d: valid=%b ser=%b last=%b, want 1 %b %b",
                 i, out_valid2, ser2, out_last2, e, (i == 3 + Extra));
      end
      tick();
    end
    tests++;
    if (empty2 !== 1'b1) begin
      fails++;
      $display("FAIL lanes2 idle: empty=%b, want 1", empty2);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] w;
    w = 8'hA3;
    in_valid = 1'b1; par_in = w; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < Bpw; i++) begin
      logic exp_bit;
      exp_bit = (i < 8) ? w[7-i] : ^w;
      tests++;
      if (out_valid !== 1'b1 || ser !== exp_bit || out_last !== (i == Bpw - 1)) begin
        fails++;
        $display("FAIL backpressure beat %0d: valid=%b ser=%b last=%b, want 1 %b %b",
                 i, out_valid, ser, out_last, exp_bit, (i == Bpw - 1));
      end
      if (i == 1) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          tests++;
          if (out_valid !== 1'b1 || ser !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall %0d: valid=%b ser=%b in_ready=%b, want 1 0 0",
                     s, out_valid, ser, in_ready);
          end
        end
        out_ready = 1'b1;
      end
      tick();
    end
    tests++;
    if (empty !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL backpressure idle: empty=%b valid=%b, want 1 0", empty, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] words [2];
    words[0] = 8'hF0; words[1] = 8'h0F;
    in_valid = 1'b1; par_in = words[0]; out_ready = 1'b1;
    tick();
    par_in = words[1];
    for (int k = 0; k < 2 * Bpw; k++) begin
      int         j;
      logic [7:0] w;
      logic       exp_bit;
      j = k % Bpw;
      w = words[k / Bpw];
      exp_bit = (j < 8) ? w[7-j] : ^w;
      tests++;
      if (out_valid !== 1'b1 || ser !== exp_bit || out_last !== (j == Bpw - 1) ||
          in_ready !== (j == Bpw - 1)) begin
        fails++;
        $display("FAIL back_to_back beat %0d: valid=%b ser=%b last=%b in_ready=%b, want 1 %b %b %b",
                 k, out_valid, ser, out_last, in_ready, exp_bit, (j == Bpw - 1), (j == Bpw - 1));
      end
      tick();
      if (k == Bpw - 1) in_valid = 1'b0;
    end
    tests++;
    if (empty !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL back_to_back idle: empty=%b valid=%b, want 1 0", empty, out_valid);
    end
  endtask

  task automatic test_reset_mid_word;
    logic [7:0] w;
    in_valid = 1'b1; par_in = 8'hFF; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || empty !== 1'b1 || ser !== 1'b0 || out_last !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_word: valid=%b empty=%b ser=%b last=%b, want 0 1 0 0",
               out_valid, empty, ser, out_last);
    end
    w = 8'h01;
    in_valid = 1'b1; par_in = w;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < Bpw; i++) begin
      logic exp_bit;
      exp_bit = (i < 8) ? w[7-i] : ^w;
      tests++;
      if (out_valid !== 1'b1 || ser !== exp_bit || out_last !== (i == Bpw - 1)) begin
        fails++;
        $display("FAIL after_reset beat %0d: valid=%b ser=%b last=%b, want 1 %b %b",
                 i, out_valid, ser, out_last, exp_bit, (i == Bpw - 1));
      end
      tick();
    end
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity;
    logic [7:0] words [2];
    logic       pars [2];
    words[0] = 8'h07; pars[0] = 1'b1;
    words[1] = 8'h03; pars[1] = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      in_valid = 1'b1; par_in = words[n];
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
        logic exp_bit;
        exp_bit = (i < 8) ? words[n][7-i] : pars[n];
        tests++;
        if (ser !== exp_bit || out_last !== (i == 8)) begin
          fails++;
          $display("FAIL parity word %0d beat %0d: ser=%b last=%b, want %b %b",
                   n, i, ser, out_last, exp_bit, (i == 8));
        end
        tick();
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; par_in = '0; out_ready = 1'b0;
    in_valid2 = 1'b0; par_in2 = '0; out_ready2 = 1'b0;
    #1;
    test_reset();
    test_msb_first();
    test_lanes2_lsb();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
